// File: rtl/alu_share_ctrl_pkg.sv
// rtl/alu_share_ctrl_pkg.sv - shared opcodes, FSM states and flag indices for alu_share_ctrl
// Purpose: common definitions for the shared-ALU controller and its arbiter.
// Contents: ALU opcode constants, highest legal opcode, FSM state encoding,
//           bit positions inside rsp_flags.
package alu_share_ctrl_pkg;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;
  localparam logic [4:0] OP_MAX = OP_SRA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // rsp_flags = {err, ovf, lt, ne}
  localparam int FLAG_NE  = 0;
  localparam int FLAG_LT  = 1;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_ERR = 3;

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// rtl/alu_share_ctrl_rr_arbiter.sv - combinational round-robin arbiter
// Purpose: pick the first asserted request at or after the pointer, wrapping.
// Ports:
//   i_req   in  NUM_REQ  request vector
//   i_ptr   in  PW       highest-priority requester index
//   o_grant out NUM_REQ  one-hot grant (zero when no request)
//   o_idx   out PW       index of the granted requester
//   o_any   out 1        at least one request present
module alu_share_ctrl_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PW      = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PW-1:0]      o_idx,
  output logic               o_any
);

  // One extra bit so ptr+offset cannot wrap before the modulo fold.
  localparam int SW = PW + 1;

  logic [SW-1:0] w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_pos = {1'b0, i_ptr} + SW'(off);
      if (w_pos >= SW'(NUM_REQ)) begin
        w_pos = w_pos - SW'(NUM_REQ);
      end
      if (!o_any && i_req[w_pos[PW-1:0]]) begin
        o_any                 = 1'b1;
        o_idx                 = w_pos[PW-1:0];
        o_grant[w_pos[PW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - round-robin sharing of one combinational ALU among requesters
// Purpose: arbitrate NUM_REQ requesters onto a single ALU, hold operands for
//          EXEC_CYCLES, capture result/flags and return them on a response channel.
// Ports:
//   clock, reset (async, active-low)
//   req_valid/req_ready            per-requester request handshake (ready one-hot)
//   req_opcode/req_shamt/req_a/req_b  packed per-requester payload, slice i = requester i
//   alu_opA/opB/opcode/shamt       registered ALU inputs
//   alu_result/ne/lt/ovf           ALU outputs
//   rsp_valid/rsp_ready            per-requester response handshake (valid one-hot)
//   rsp_result/rsp_flags           captured result, flags {err, ovf, lt, ne}
//   busy                           high in EXEC or RESP
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int EXEC_CYCLES = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [5*NUM_REQ-1:0]    req_opcode,
  input  logic [5*NUM_REQ-1:0]    req_shamt,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [31:0]             alu_opA,
  output logic [31:0]             alu_opB,
  output logic [4:0]              alu_opcode,
  output logic [4:0]              alu_shamt,
  input  logic [31:0]             alu_result,
  input  logic                    alu_ne,
  input  logic                    alu_lt,
  input  logic                    alu_ovf,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [31:0]             rsp_result,
  output logic [3:0]              rsp_flags,
  output logic                    busy
);

  localparam int         PW       = $clog2(NUM_REQ);
  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t             r_state;
  state_t             w_next;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      r_owner;
  logic [3:0]         r_cnt;
  logic [31:0]        r_opa;
  logic [31:0]        r_opb;
  logic [4:0]         r_opcode;
  logic [4:0]         r_shamt;
  logic [31:0]        r_result;
  logic [3:0]         r_flags;

  logic [NUM_REQ-1:0] w_grant;
  logic [PW-1:0]      w_gidx;
  logic               w_any;
  logic [4:0]         w_sel_op;
  logic [4:0]         w_sel_shamt;
  logic [31:0]        w_sel_a;
  logic [31:0]        w_sel_b;
  logic               w_hs;
  logic               w_legal;
  logic               w_accept;
  logic               w_cnt_done;
  logic [PW-1:0]      w_ptr_next;
  logic [3:0]         w_cap_flags;
  logic [3:0]         w_err_flags;

  alu_share_ctrl_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  assign w_sel_op    = req_opcode[5*w_gidx +: 5];
  assign w_sel_shamt = req_shamt[5*w_gidx +: 5];
  assign w_sel_a     = req_a[32*w_gidx +: 32];
  assign w_sel_b     = req_b[32*w_gidx +: 32];

  assign w_hs       = (r_state == ST_IDLE) && w_any;
  assign w_legal    = (w_sel_op <= OP_MAX);
  assign w_accept   = (r_state == ST_RESP) && rsp_ready[r_owner];
  assign w_cnt_done = (r_cnt == 4'd0);
  assign w_ptr_next = (r_owner == PW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

  always_comb begin
    w_cap_flags           = '0;
    w_cap_flags[FLAG_NE]  = alu_ne;
    w_cap_flags[FLAG_LT]  = alu_lt;
    w_cap_flags[FLAG_OVF] = alu_ovf;
    w_err_flags           = '0;
    w_err_flags[FLAG_ERR] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    rsp_valid = '0;
    busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = w_grant;
        if (w_hs) begin
          // Illegal opcodes skip the ALU entirely and answer with err set.
          w_next = w_legal ? ST_EXEC : ST_RESP;
        end
      end
      ST_EXEC: begin
        busy = 1'b1;
        if (w_cnt_done) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        busy               = 1'b1;
        rsp_valid[r_owner] = 1'b1;
        if (w_accept) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr    <= '0;
      r_owner  <= '0;
      r_cnt    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_opcode <= '0;
      r_shamt  <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_owner <= w_gidx;
            if (w_legal) begin
              r_opa    <= w_sel_a;
              r_opb    <= w_sel_b;
              r_opcode <= w_sel_op;
              r_shamt  <= w_sel_shamt;
              r_cnt    <= CNT_INIT;
            end else begin
              r_result <= '0;
              r_flags  <= w_err_flags;
            end
          end
        end
        ST_EXEC: begin
          if (w_cnt_done) begin
            r_result <= alu_result;
            r_flags  <= w_cap_flags;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (w_accept) begin
            r_ptr <= w_ptr_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_opA    = r_opa;
  assign alu_opB    = r_opb;
  assign alu_opcode = r_opcode;
  assign alu_shamt  = r_shamt;
  assign rsp_result = r_result;
  assign rsp_flags  = r_flags;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - directed self-checking bench for alu_share_ctrl
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;

  localparam int N = 2;

  logic           clock;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [5*N-1:0] req_opcode;
  logic [5*N-1:0] req_shamt;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [31:0]    alu_opA;
  logic [31:0]    alu_opB;
  logic [4:0]     alu_opcode;
  logic [4:0]     alu_shamt;
  logic [31:0]    alu_result;
  logic           alu_ne;
  logic           alu_lt;
  logic           alu_ovf;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [31:0]    rsp_result;
  logic [3:0]     rsp_flags;
  logic           busy;

  int n_checks = 0;
  int n_pass   = 0;

  alu_share_ctrl #(.NUM_REQ(N), .EXEC_CYCLES(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_shamt  (req_shamt),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_opA    (alu_opA),
    .alu_opB    (alu_opB),
    .alu_opcode (alu_opcode),
    .alu_shamt  (alu_shamt),
    .alu_result (alu_result),
    .alu_ne     (alu_ne),
    .alu_lt     (alu_lt),
    .alu_ovf    (alu_ovf),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in for the shared ALU: ne/lt only from SUB, ovf only from ADD/SUB.
  logic [31:0] alu_tmp;
  always_comb begin
    alu_tmp    = '0;
    alu_result = '0;
    alu_ne     = 1'b0;
    alu_lt     = 1'b0;
    alu_ovf    = 1'b0;
    case (alu_opcode)
      OP_ADD: begin
        alu_tmp    = alu_opA + alu_opB;
        alu_result = alu_tmp;
        alu_ovf    = (alu_opA[31] == alu_opB[31]) && (alu_tmp[31] != alu_opA[31]);
      end
      OP_SUB: begin
        alu_tmp    = alu_opA - alu_opB;
        alu_result = alu_tmp;
        alu_ovf    = (alu_opA[31] != alu_opB[31]) && (alu_tmp[31] != alu_opA[31]);
        alu_ne     = (alu_opA != alu_opB);
        alu_lt     = ($signed(alu_opA) < $signed(alu_opB));
      end
      OP_AND: alu_result = alu_opA & alu_opB;
      OP_OR:  alu_result = alu_opA | alu_opB;
      OP_SLL: alu_result = alu_opA << alu_shamt;
      OP_SRA: alu_result = $signed(alu_opA) >>> alu_shamt;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] op, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b);
    req_opcode[5*i +: 5]  = op;
    req_shamt[5*i +: 5]   = sh;
    req_a[32*i +: 32]     = a;
    req_b[32*i +: 32]     = b;
  endtask

  task automatic accept(input int i);
    rsp_ready    = '0;
    rsp_ready[i] = 1'b1;
    tick();
    rsp_ready = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset      = 1'b0;
    req_valid  = '0;
    req_opcode = '0;
    req_shamt  = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = '0;
    tick();
    tick();
    #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_opA", alu_opA, 32'h0);
    check("rst_result", rsp_result, 32'h0);
    check("rst_flags", rsp_flags, 4'h0);
    reset = 1'b1;
    tick();

    // 1: r0 ADD 5+3
    set_req(0, OP_ADD, 5'd0, 32'd5, 32'd3);
    req_valid = 2'b01;
    #1;
    check("t1_grant", req_ready, 2'b01);
    tick();
    req_valid = '0;
    #1;
    check("t1_exec_rsp_valid", rsp_valid, 2'b00);
    check("t1_exec_busy", busy, 1'b1);
    check("t1_exec_req_ready", req_ready, 2'b00);
    check("t1_opA", alu_opA, 32'd5);
    check("t1_opB", alu_opB, 32'd3);
    tick();
    check("t1_rsp_valid", rsp_valid, 2'b01);
    check("t1_result", rsp_result, 32'd8);
    check("t1_flags", rsp_flags, 4'b0000);
    accept(0);
    check("t1_idle_busy", busy, 1'b0);

    // 2: tie after reset, r0 first then r1
    do_reset();
    set_req(0, OP_SUB, 5'd0, 32'd7, 32'd9);
    set_req(1, OP_AND, 5'd0, 32'hF0, 32'h3C);
    req_valid = 2'b11;
    #1;
    check("t2_grant_r0", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    tick();
    check("t2_rsp_valid_r0", rsp_valid, 2'b01);
    check("t2_result_r0", rsp_result, 32'hFFFFFFFE);
    check("t2_flags_r0", rsp_flags, 4'b0011);
    accept(0);
    check("t2_grant_r1", req_ready, 2'b10);
    tick();
    req_valid = '0;
    tick();
    check("t2_rsp_valid_r1", rsp_valid, 2'b10);
    check("t2_result_r1", rsp_result, 32'h30);
    check("t2_flags_r1", rsp_flags, 4'b0000);
    accept(1);

    // 3: signed overflow on ADD
    set_req(0, OP_ADD, 5'd0, 32'h7FFFFFFF, 32'd1);
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    tick();
    check("t3_rsp_valid", rsp_valid, 2'b01);
    check("t3_result", rsp_result, 32'h80000000);
    check("t3_flags", rsp_flags, 4'b0100);
    accept(0);

    // 4: illegal opcode answers next cycle, ALU regs untouched
    set_req(0, 5'b01111, 5'd3, 32'hDEAD, 32'hBEEF);
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    check("t4_rsp_valid", rsp_valid, 2'b01);
    check("t4_result", rsp_result, 32'h0);
    check("t4_flags", rsp_flags, 4'b1000);
    check("t4_opA_held", alu_opA, 32'h7FFFFFFF);
    check("t4_opB_held", alu_opB, 32'd1);
    check("t4_opcode_held", alu_opcode, OP_ADD);
    accept(0);

    // 5: response back-pressure, non-owner rsp_ready ignored
    set_req(0, OP_OR, 5'd0, 32'hA0, 32'h05);
    req_valid = 2'b01;
    tick();
    set_req(1, OP_SRA, 5'd4, 32'h80000000, 32'h0);
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    tick();
    for (int k = 0; k < 10; k++) begin
      check("t5_hold_valid", rsp_valid, 2'b01);
      check("t5_hold_result", rsp_result, 32'hA5);
      check("t5_hold_flags", rsp_flags, 4'b0000);
      check("t5_hold_req_ready", req_ready, 2'b00);
      tick();
    end
    accept(0);
    check("t5_grant_r1", req_ready, 2'b10);
    tick();
    req_valid = '0;
    tick();
    check("t5_rsp_valid_r1", rsp_valid, 2'b10);
    check("t5_result_r1", rsp_result, 32'hF8000000);
    check("t5_shamt", alu_shamt, 5'd4);
    accept(1);

    // 6: move pointer to 1, then reset in the middle of an r1 op
    set_req(0, OP_ADD, 5'd0, 32'd1, 32'd1);
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    tick();
    check("t6_pre_result", rsp_result, 32'd2);
    accept(0);
    set_req(1, OP_ADD, 5'd0, 32'd2, 32'd2);
    req_valid = 2'b10;
    tick();
    req_valid = '0;
    check("t6_exec_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_rsp_valid", rsp_valid, 2'b00);
    check("t6_rst_opA", alu_opA, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_no_rsp", rsp_valid, 2'b00);
    end
    set_req(0, OP_ADD, 5'd0, 32'd4, 32'd4);
    set_req(1, OP_ADD, 5'd0, 32'd6, 32'd6);
    req_valid = 2'b11;
    #1;
    check("t6_tie_r0", req_ready, 2'b01);
    req_valid = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
